// File: rtl/count_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : count_ctrl
// Function : Front-panel controller. Synchronises and debounces two buttons,
//            arbitrates them into step strobes, owns the 4-bit counter and
//            drives the blinking LED display.
//            Hold-to-repeat is built only when COUNT_CTRL_AUTOREPEAT_EN is
//            defined.
// Revision : 1.0 - initial release
// ============================================================================
module count_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 6250000,
  parameter int BLINK_HALF      = 25000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_plus,
  input  logic       btn_minus,
  output logic [3:0] num,
  output logic       step_inc,
  output logic       step_dec,
  output logic [3:0] led,
  output logic       locked
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int BL_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

  if (DEBOUNCE_CYCLES < 2 || BLINK_HALF < 1 ||
      REPEAT_PERIOD < 1 || REPEAT_PERIOD > REPEAT_DELAY) begin : g_bad_params
    $error("count_ctrl: invalid parameter set");
  end

  logic [1:0] btn_raw;
  logic [1:0] deb;
  logic       p;
  logic       m;

  assign btn_raw = {btn_minus, btn_plus};
  assign p       = deb[0];
  assign m       = deb[1];

  // Debounced level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  for (genvar gi = 0; gi < 2; gi++) begin : g_btn
    logic            sync1_q;
    logic            sync2_q;
    logic            level_q;
    logic [DB_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        sync1_q <= 1'b0;
        sync2_q <= 1'b0;
        level_q <= 1'b0;
        cnt_q   <= '0;
      end else begin
        sync1_q <= btn_raw[gi];
        sync2_q <= sync1_q;
        if (sync2_q == level_q) begin
          cnt_q <= '0;
        end else if (cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          level_q <= sync2_q;
          cnt_q   <= '0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end

    assign deb[gi] = level_q;
  end

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_HOLD_P = 2'd1,
    S_HOLD_M = 2'd2,
    S_LOCK   = 2'd3
  } state_t;

  state_t state_q;
  state_t state_d;
  logic   inc_d;
  logic   dec_d;
  logic   inc_q;
  logic   dec_q;
  logic   locked_q;

`ifdef COUNT_CTRL_AUTOREPEAT_EN
  localparam int RT_W = (REPEAT_DELAY > 1) ? $clog2(REPEAT_DELAY) : 1;

  logic [RT_W-1:0] rep_cnt_q;
  logic            rep_due;

  assign rep_due = (rep_cnt_q == RT_W'(REPEAT_DELAY - 1));

  // Repeat steps reload the timer so the next one lands REPEAT_PERIOD later.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rep_cnt_q <= '0;
    end else if (inc_d || dec_d) begin
      rep_cnt_q <= (state_q == S_IDLE) ? '0 : RT_W'(REPEAT_DELAY - REPEAT_PERIOD);
    end else if (state_d == S_HOLD_P || state_d == S_HOLD_M) begin
      rep_cnt_q <= rep_cnt_q + 1'b1;
    end else begin
      rep_cnt_q <= '0;
    end
  end
`else
`endif

  always_comb begin
    state_d = state_q;
    inc_d   = 1'b0;
    dec_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (p && m) begin
          state_d = S_LOCK;
        end else if (p) begin
          inc_d   = 1'b1;
          state_d = S_HOLD_P;
        end else if (m) begin
          dec_d   = 1'b1;
          state_d = S_HOLD_M;
        end
      end
      S_HOLD_P: begin
        if (m) begin
          state_d = S_LOCK;
        end else if (!p) begin
          state_d = S_IDLE;
        end
`ifdef COUNT_CTRL_AUTOREPEAT_EN
        else if (rep_due) begin
          inc_d = 1'b1;
        end
`endif
      end
      S_HOLD_M: begin
        if (p) begin
          state_d = S_LOCK;
        end else if (!m) begin
          state_d = S_IDLE;
        end
`ifdef COUNT_CTRL_AUTOREPEAT_EN
        else if (rep_due) begin
          dec_d = 1'b1;
        end
`endif
      end
      S_LOCK: begin
        if (!p && !m) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      inc_q    <= 1'b0;
      dec_q    <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      inc_q    <= inc_d;
      dec_q    <= dec_d;
      locked_q <= (state_d == S_LOCK);
    end
  end

  logic [3:0]      num_q;
  logic [3:0]      num_d;
  logic [3:0]      led_q;
  logic [3:0]      led_d;
  logic [BL_W-1:0] blink_q;
  logic [BL_W-1:0] blink_d;
  logic            show_q;
  logic            show_d;

  // A step restarts the blink period in the show phase so the new value is seen at once.
  always_comb begin
    num_d   = num_q;
    blink_d = blink_q;
    show_d  = show_q;
    if (inc_q) begin
      num_d = num_q + 4'd1;
    end else if (dec_q) begin
      num_d = num_q - 4'd1;
    end
    if (inc_q || dec_q) begin
      blink_d = '0;
      show_d  = 1'b1;
    end else if (blink_q == BL_W'(BLINK_HALF - 1)) begin
      blink_d = '0;
      show_d  = ~show_q;
    end else begin
      blink_d = blink_q + 1'b1;
    end
    led_d = show_d ? num_d : 4'd0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      num_q   <= 4'd0;
      led_q   <= 4'd0;
      blink_q <= '0;
      show_q  <= 1'b1;
    end else begin
      num_q   <= num_d;
      led_q   <= led_d;
      blink_q <= blink_d;
      show_q  <= show_d;
    end
  end

  assign num      = num_q;
  assign led      = led_q;
  assign step_inc = inc_q;
  assign step_dec = dec_q;
  assign locked   = locked_q;

endmodule
`default_nettype wire

// File: tb/tb_count_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_count_ctrl
// Function : Directed self-checking bench for count_ctrl (small timing params).
// Revision : 1.0 - initial release
// ============================================================================
module tb_count_ctrl;

  localparam int DEB  = 4;
  localparam int RDLY = 20;
  localparam int RPER = 5;
  localparam int BLNK = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_plus;
  logic       btn_minus;
  logic [3:0] num;
  logic [3:0] led;
  logic       step_inc;
  logic       step_dec;
  logic       locked;

  int checks    = 0;
  int errors    = 0;
  int inc_seen  = 0;
  int dec_seen  = 0;
  int both_seen = 0;
  int base_i;
  int base_d;

  always #5 clk = ~clk;

  count_ctrl #(
    .DEBOUNCE_CYCLES(DEB),
    .REPEAT_DELAY   (RDLY),
    .REPEAT_PERIOD  (RPER),
    .BLINK_HALF     (BLNK)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .btn_plus (btn_plus),
    .btn_minus(btn_minus),
    .num      (num),
    .step_inc (step_inc),
    .step_dec (step_dec),
    .led      (led),
    .locked   (locked)
  );

  always @(posedge clk) begin
    if (step_inc) inc_seen <= inc_seen + 1;
    if (step_dec) dec_seen <= dec_seen + 1;
    if (step_inc && step_dec) both_seen <= both_seen + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press_plus(input string tag, input logic [3:0] exp);
    btn_plus = 1'b1;
    cyc(8);
    chk(tag, num, exp);
    btn_plus = 1'b0;
    cyc(10);
  endtask

  task automatic press_minus(input string tag, input logic [3:0] exp);
    btn_minus = 1'b1;
    cyc(8);
    chk(tag, num, exp);
    btn_minus = 1'b0;
    cyc(10);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    reset     = 1'b0;
    btn_plus  = 1'b0;
    btn_minus = 1'b0;
    cyc(3);
    chk("rst_num", num, 0);
    chk("rst_led", led, 0);
    chk("rst_inc", step_inc, 0);
    chk("rst_dec", step_dec, 0);
    chk("rst_locked", locked, 0);
    reset = 1'b1;
    cyc(2);

    // Clean press: strobe 7 cycles after the raw edge, count visible one cycle later.
    btn_plus = 1'b1;
    cyc(6);
    chk("press_early", step_inc, 0);
    cyc(1);
    chk("press_strobe", step_inc, 1);
    chk("press_num_before", num, 0);
    cyc(1);
    chk("press_pulse_end", step_inc, 0);
    chk("press_num", num, 1);
    chk("press_led", led, 1);

`ifdef COUNT_CTRL_AUTOREPEAT_EN
    cyc(18);
    chk("rep_quiet", step_inc, 0);
    cyc(1);
    chk("rep_first", step_inc, 1);
    cyc(5);
    chk("rep_second", step_inc, 1);
    cyc(5);
    chk("rep_third", step_inc, 1);
    cyc(26);
    chk("rep_num9", num, 9);
`else
    base_i = inc_seen;
    cyc(100);
    chk("no_repeat", inc_seen - base_i, 0);
    chk("no_repeat_num", num, 1);
`endif

    // Asynchronous reset while the button is still held.
    reset = 1'b0;
    #1;
    chk("rst_mid_num", num, 0);
    chk("rst_mid_led", led, 0);
    chk("rst_mid_inc", step_inc, 0);
    chk("rst_mid_locked", locked, 0);
    @(negedge clk);
    reset = 1'b1;
    cyc(6);
    chk("rst_rel_early", step_inc, 0);
    cyc(1);
    chk("rst_rel_strobe", step_inc, 1);
    cyc(1);
    chk("rst_rel_num", num, 1);
    btn_plus = 1'b0;
    cyc(10);

    // Wrap in both directions from zero.
    reset = 1'b0;
    cyc(2);
    reset = 1'b1;
    cyc(2);
    base_i = inc_seen;
    for (int i = 1; i <= 16; i++) press_plus("wrap_inc", 4'(i));
    chk("wrap_inc_count", inc_seen - base_i, 16);
    base_d = dec_seen;
    for (int i = 1; i <= 16; i++) press_minus("wrap_dec", 4'(16 - i));
    chk("wrap_dec_count", dec_seen - base_d, 16);

    // Bouncing minus button, then a stable press.
    base_d = dec_seen;
    for (int i = 0; i < 10; i++) begin
      btn_minus = (i % 2 == 0);
      cyc(2);
    end
    chk("bounce_quiet", dec_seen - base_d, 0);
    btn_minus = 1'b1;
    cyc(6);
    chk("bounce_early", step_dec, 0);
    cyc(1);
    chk("bounce_strobe", step_dec, 1);
    cyc(1);
    chk("bounce_num", num, 15);
    chk("bounce_count", dec_seen - base_d, 1);
    btn_minus = 1'b0;
    cyc(10);

    // Arbitration and lockout.
    base_i    = inc_seen;
    base_d    = dec_seen;
    btn_plus  = 1'b1;
    btn_minus = 1'b1;
    cyc(10);
    chk("arb_locked", locked, 1);
    chk("arb_no_steps", (inc_seen - base_i) + (dec_seen - base_d), 0);
    btn_plus = 1'b0;
    cyc(10);
    chk("arb_still_locked", locked, 1);
    btn_minus = 1'b0;
    cyc(10);
    chk("arb_unlocked", locked, 0);
    chk("arb_num", num, 15);
    btn_plus = 1'b1;
    cyc(8);
    chk("arb_hold_num", num, 0);
    base_d    = dec_seen;
    btn_minus = 1'b1;
    cyc(10);
    chk("arb_hold_lock", locked, 1);
    chk("arb_hold_no_dec", dec_seen - base_d, 0);
    chk("arb_hold_num2", num, 0);
    btn_plus  = 1'b0;
    btn_minus = 1'b0;
    cyc(10);
    chk("arb_release", locked, 0);

    // Blink schedule around num = 5, then a step landing in the blank phase.
    for (int i = 1; i <= 4; i++) press_plus("blink_setup", 4'(i));
    btn_plus = 1'b1;
    cyc(8);
    chk("blink_show0", led, 5);
    btn_plus = 1'b0;
    cyc(7);
    chk("blink_show_end", led, 5);
    cyc(1);
    chk("blink_blank0", led, 0);
    cyc(7);
    chk("blink_blank_end", led, 0);
    cyc(1);
    chk("blink_show1", led, 5);
    cyc(2);
    btn_plus = 1'b1;
    cyc(7);
    chk("blink_step_strobe", step_inc, 1);
    chk("blink_step_blank", led, 0);
    cyc(1);
    chk("blink_step_led", led, 6);
    chk("blink_step_num", num, 6);
    btn_plus = 1'b0;
    cyc(7);
    chk("blink_restart_show", led, 6);
    cyc(1);
    chk("blink_restart_blank", led, 0);
    cyc(10);

    chk("never_both", both_seen, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/count_ctrl.md
# count_ctrl

Front-panel controller for the 4-bit counter/LED display. Synchronizes and debounces the two push-buttons and arbitrates between them into single step commands. Owns the counter value and schedules the blinking LED display phase, with optional hold-to-repeat. Sits between the raw board pins (buttons, LEDs) and the rest of the board logic, which reads `num` and the step strobes.

## Interface
- `DEBOUNCE_CYCLES`, 500000: consecutive stable cycles required to accept a button level change (≥2).
- `REPEAT_DELAY`, 25000000: hold cycles after the first step before auto-repeat begins.
- `REPEAT_PERIOD`, 6250000: cycles between auto-repeat steps.
- `BLINK_HALF`, 25000000: cycles per display half-period (show / blank).

- `clk` in 1: single clock; all state on rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `btn_plus` in 1: raw increment button, active-high, asynchronous to `clk`.
- `btn_minus` in 1: raw decrement button, active-high, asynchronous to `clk`.
- `num` out 4: current counter value.
- `step_inc` out 1: one-cycle strobe, counter incremented.
- `step_dec` out 1: one-cycle strobe, counter decremented.
- `led` out 4: display; `led[i] = num[i]` in show phase, 0 in blank phase.
- `locked` out 1: high while both buttons are held (arbitration lockout).

## Operation
- Each button passes through a 2-FF synchronizer, then a debouncer. The debounced level changes only after the synchronized input differs from it for `DEBOUNCE_CYCLES` consecutive cycles. Any bounce restarts the count.
- Arbiter FSM on the debounced levels `p`, `m`:
  - IDLE: `p&!m` → step inc, go HOLD_P. `m&!p` → step dec, go HOLD_M. `p&m` → LOCK, no step.
  - HOLD_P / HOLD_M: own button released → IDLE. Other button becomes pressed → LOCK, no step. Auto-repeat behaviour: see Configuration.
  - LOCK: `locked`=1. Leaves for IDLE only when `p=0` and `m=0`.
- Counter arithmetic: `num` is modulo 16. Increment 15→0; decrement 0→15. No saturation.
- Display scheduler:
  - Blink counter runs 0..`BLINK_HALF`-1. At wrap, the phase toggles show↔blank.
  - Every step restarts the blink counter and forces the show phase, so a new value is visible immediately.
- Reset (any time, including mid-debounce or mid-repeat):
  - `num`=0, `led`=0, `step_inc`=`step_dec`=0, `locked`=0.
  - FSM=IDLE, debounced levels=0, synchronizers=0, all counters=0, phase=show.
  - After release, a button already held is treated as a new press once debounced.

## Timing
- A raw edge held stable at cycle 0 produces a debounced edge at cycle `DEBOUNCE_CYCLES`+2.
- The step strobe is asserted on the cycle after the debounced edge.
- `num` and `led` show the new value on the cycle after the strobe. They are registered, with no combinational path from the buttons.
- `step_inc` and `step_dec` are never high together. Each strobe is exactly one cycle wide.
- `locked` asserts on the cycle after the FSM enters LOCK and deasserts on the cycle after it leaves.
- Phase toggles every `BLINK_HALF` cycles when no steps occur.

## Configuration
- `COUNT_CTRL_AUTOREPEAT_EN` defined:
  - In HOLD_P/HOLD_M, a hold timer counts from the first step.
  - At `REPEAT_DELAY` cycles, a further step is issued, then one every `REPEAT_PERIOD` cycles while the button remains held.
  - The timer clears on release, LOCK or reset.
- Not defined: exactly one step per debounced press. The hold timer logic is absent and HOLD states wait only for release.

## Test plan
Bench parameters: `DEBOUNCE_CYCLES`=4, `REPEAT_DELAY`=20, `REPEAT_PERIOD`=5, `BLINK_HALF`=8.
- Reset mid-operation: drive `reset`=0 for 1 cycle asynchronously while `num`=9 and repeating. Require all outputs 0 immediately and FSM IDLE. A held button gives its first step 7 cycles after release (6-cycle debounce plus strobe).
- Clean press: `btn_plus` 0→1 held, from `num`=0.
  - `step_inc` single pulse 7 cycles after the edge; `num`=1 the cycle after.
  - Without the macro, no further steps for 100 cycles.
  - With the macro, steps at +20, +25, +30… cycles after the first.
- Bounce: `btn_minus` toggling every 2 cycles for 20 cycles, then stable high. Require no step during bouncing and exactly one `step_dec` 7 cycles after settling. From `num`=0, `num` becomes 15.
- Wrap: 16 clean `btn_plus` presses from `num`=0 → `num` sequence 1..15, 0. Matching decrement presses from 0 → 15.
- Arbitration: press both in the same cycle → no strobes, `locked`=1. Release only `btn_plus` → still locked. Release both → `locked`=0 and `num` unchanged. Then press `btn_minus` during HOLD_P → LOCK, no `step_dec`.
- Blink: idle with `num`=5 → `led` alternates 5 / 0 every 8 cycles. A step during the blank phase → `led` shows the new value on the next cycle, and the blink counter restarts.
